// File: rtl/lag_correlator_engine.sv
`default_nettype none
// ============================================================================
// Module   : lag_correlator_engine
// Purpose  : Counts coincidences between every pair of pulse inputs at every
//            lag, plus single-channel totals, over a programmable window of
//            clock cycles. At each window end the counts are copied into a
//            shadow bank and streamed out one word per valid/ready beat.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              single clock
//   reset_n          asynchronous active-low reset
//   pulse_in         asynchronous pulse inputs, NUM_INPUTS bits
//   enable           run integration windows while high
//   integration_time window length in clk cycles, 0 disables windowing
//   out_valid        readout word valid
//   out_ready        consumer accepts the current word
//   out_data         count value, RESOLUTION bits
//   out_index        word index, IDX_W bits
//   out_last         high on the word at index NUM_WORDS-1
//   window_tick      one-cycle pulse in the last cycle of each window
//   overrun          sticky, set when a snapshot is dropped during a stream
//   overrun_clear    synchronous clear of overrun
//   out_sat          (CORR_SATURATE_EN only) a counter saturated in the
//                    window being streamed
// Word map
//   pair (l,d), l<d, lag f  -> pair_ordinal*LAGS + f  (l ascending, d ascending)
//   single i                -> NUM_PAIRS*LAGS + i
// Build option
//   CORR_SATURATE_EN  defined: counters saturate and out_sat is present;
//                     undefined: counters wrap modulo 2^RESOLUTION.
// ============================================================================
module lag_correlator_engine #(
  parameter  int NUM_INPUTS = 8,
  parameter  int MAX_DELAY  = 50,
  parameter  int RESOLUTION = 8,
  parameter  int TIME_WIDTH = 32,
  localparam int LAGS       = MAX_DELAY | 1,
  localparam int NUM_PAIRS  = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
  localparam int NUM_WORDS  = NUM_PAIRS * LAGS + NUM_INPUTS,
  localparam int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] pulse_in,
  input  logic                  enable,
  input  logic [TIME_WIDTH-1:0] integration_time,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RESOLUTION-1:0] out_data,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  window_tick,
  output logic                  overrun,
`ifdef CORR_SATURATE_EN
  output logic                  out_sat,
`endif
  input  logic                  overrun_clear
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  // --------------------------------------------------------------------------
  // Input path: first flop of the synchronizer, then a LAGS-deep shift
  // register whose bit 0 is the second synchronizer flop (tap 0).
  // --------------------------------------------------------------------------
  logic [NUM_INPUTS-1:0]           sync1_q;
  logic [NUM_INPUTS-1:0][LAGS-1:0] tap_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      tap_q   <= '0;
    end else begin
      sync1_q <= pulse_in;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        tap_q[i] <= (tap_q[i] << 1) | LAGS'(sync1_q[i]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Coincidence and single terms, one bit per output word
  // --------------------------------------------------------------------------
  logic [NUM_WORDS-1:0] term;

  for (genvar l = 0; l < NUM_INPUTS; l++) begin : g_left
    for (genvar d = l + 1; d < NUM_INPUTS; d++) begin : g_right
      // Ordinal of pair (l,d) when pairs are enumerated l-major.
      localparam int PAIR = l * NUM_INPUTS - (l * (l + 1)) / 2 + (d - l - 1);
      for (genvar f = 0; f < LAGS; f++) begin : g_lag
        assign term[PAIR*LAGS + f] = tap_q[l][f] & tap_q[d][LAGS-1-f];
      end
    end
  end

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_single
    assign term[NUM_PAIRS*LAGS + i] = tap_q[i][0];
  end

  // --------------------------------------------------------------------------
  // Live counters. cnt_fin is the count including this cycle's term; it is
  // both the next live value and, on the window's last cycle, the snapshot.
  // --------------------------------------------------------------------------
  logic [NUM_WORDS-1:0][RESOLUTION-1:0] cnt_q;
  logic [NUM_WORDS-1:0][RESOLUTION-1:0] cnt_fin;
`ifdef CORR_SATURATE_EN
  logic [NUM_WORDS-1:0]                 sat_hit;
`endif

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
`ifdef CORR_SATURATE_EN
    assign sat_hit[k] = term[k] & (&cnt_q[k]);
    assign cnt_fin[k] = sat_hit[k] ? cnt_q[k] : cnt_q[k] + RESOLUTION'(term[k]);
`else
    assign cnt_fin[k] = cnt_q[k] + RESOLUTION'(term[k]);
`endif
  end

  // --------------------------------------------------------------------------
  // Window control
  // --------------------------------------------------------------------------
  logic                  run_q;
  logic [TIME_WIDTH-1:0] wcnt_q;
  logic [TIME_WIDTH-1:0] tlen_q;
  logic                  restart;
`ifdef CORR_SATURATE_EN
  logic                  sat_win_q;
  logic                  sat_any;
  assign sat_any = |sat_hit;
`endif

  // Gating with enable means a window whose last cycle sees enable low is
  // discarded along with the rest of it.
  assign window_tick = run_q & enable & (wcnt_q == tlen_q - TIME_WIDTH'(1));
  // A new window begins after the last cycle of the previous one, or on the
  // first enabled cycle; integration_time is sampled only at that point.
  assign restart     = ~run_q | window_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q     <= 1'b0;
      wcnt_q    <= '0;
      tlen_q    <= '0;
      cnt_q     <= '0;
`ifdef CORR_SATURATE_EN
      sat_win_q <= 1'b0;
`endif
    end else if (!enable) begin
      run_q     <= 1'b0;
      wcnt_q    <= '0;
      cnt_q     <= '0;
`ifdef CORR_SATURATE_EN
      sat_win_q <= 1'b0;
`endif
    end else if (restart) begin
      // The last cycle's term already went into cnt_fin (the snapshot), so
      // the live bank restarts empty and the next edge counts the first
      // cycle of the new window: every cycle is counted exactly once.
      run_q     <= |integration_time;
      tlen_q    <= integration_time;
      wcnt_q    <= '0;
      cnt_q     <= '0;
`ifdef CORR_SATURATE_EN
      sat_win_q <= 1'b0;
`endif
    end else begin
      wcnt_q    <= wcnt_q + TIME_WIDTH'(1);
      cnt_q     <= cnt_fin;
`ifdef CORR_SATURATE_EN
      sat_win_q <= sat_win_q | sat_any;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Shadow bank and readout FSM
  // --------------------------------------------------------------------------
  logic [NUM_WORDS-1:0][RESOLUTION-1:0] shadow_q;
  logic [0:0]                           state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic                                 overrun_q, overrun_d;
  logic                                 snap;
  logic                                 beat;
  logic                                 at_last;

  assign snap    = window_tick & (state_q == S_IDLE);
  assign beat    = (state_q == S_STREAM) & out_ready;
  assign at_last = (idx_q == IDX_W'(NUM_WORDS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    // A new drop wins over a simultaneous clear.
    overrun_d = (overrun_q & ~overrun_clear) | (window_tick & (state_q == S_STREAM));
    if (snap) begin
      state_d = S_STREAM;
      idx_d   = '0;
    end else if (beat) begin
      if (at_last) begin
        state_d = S_IDLE;
        idx_d   = '0;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      if (snap) begin
        shadow_q <= cnt_fin;
      end
    end
  end

`ifdef CORR_SATURATE_EN
  logic sat_snap_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_snap_q <= 1'b0;
    end else if (snap) begin
      sat_snap_q <= sat_win_q | sat_any;
    end
  end

  assign out_sat = sat_snap_q;
`endif

  // All readout outputs come from registers, so out_ready never reaches
  // out_valid combinationally.
  assign out_valid = (state_q == S_STREAM);
  assign out_index = idx_q;
  assign out_data  = shadow_q[idx_q];
  assign out_last  = out_valid & at_last;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_lag_correlator_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_lag_correlator_engine
// Purpose  : Self-checking bench for lag_correlator_engine with 3 inputs and
//            5 lags (18 words). Expected streams are queued when a window is
//            set up and compared beat by beat as the DUT streams them.
// Revision : 1.0  initial release
// ============================================================================
module tb_lag_correlator_engine;

  localparam int NI   = 3;
  localparam int MD   = 4;
  localparam int RES  = 8;
  localparam int TW   = 16;
  localparam int LAGS = 5;
  localparam int NP   = 3;
  localparam int NW   = NP * LAGS + NI;
  localparam int IW   = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NI-1:0] pulse_in;
  logic          enable;
  logic [TW-1:0] integration_time;
  logic          out_valid;
  logic          out_ready;
  logic [RES-1:0] out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          window_tick;
  logic          overrun;
  logic          overrun_clear;
`ifdef CORR_SATURATE_EN
  logic          out_sat;
`endif

  always #5 clk = ~clk;

  lag_correlator_engine #(
    .NUM_INPUTS (NI),
    .MAX_DELAY  (MD),
    .RESOLUTION (RES),
    .TIME_WIDTH (TW)
  ) u_dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pulse_in         (pulse_in),
    .enable           (enable),
    .integration_time (integration_time),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_index        (out_index),
    .out_last         (out_last),
    .window_tick      (window_tick),
    .overrun          (overrun),
`ifdef CORR_SATURATE_EN
    .out_sat          (out_sat),
`endif
    .overrun_clear    (overrun_clear)
  );

  typedef struct {
    int idx;
    int data;
    int sat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   exp_words[NW];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected words when the inputs in hi are held steadily high for the
  // whole window: every pair of high inputs and every high single reads n.
  task automatic build_const(input logic [NI-1:0] hi, input int n);
    int p;
    p = 0;
    for (int l = 0; l < NI; l++) begin
      for (int d = l + 1; d < NI; d++) begin
        for (int f = 0; f < LAGS; f++) begin
          exp_words[p*LAGS + f] = (hi[l] && hi[d]) ? n : 0;
        end
        p++;
      end
    end
    for (int i = 0; i < NI; i++) begin
      exp_words[NP*LAGS + i] = hi[i] ? n : 0;
    end
  endtask

  task automatic push_stream(input int sat);
    exp_t x;
    for (int k = 0; k < NW; k++) begin
      x.idx  = k;
      x.data = exp_words[k];
      x.sat  = sat;
      sb.push_back(x);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (window_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  task automatic wait_index(input int target, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid && (out_index == IW'(target))) begin
        seen = 1'b1;
        break;
      end
      cyc(1);
    end
    if (!seen) check("index_timeout", 0, 1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      cyc(1);
    end
    check("words_left", sb.size(), 0);
  endtask

  // Scoreboard: a beat happens at the next rising edge when valid && ready.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        e = sb.pop_front();
        check("beat_index", 32'(out_index), e.idx);
        check("beat_data",  32'(out_data),  e.data);
        check("beat_last",  32'(out_last),  (e.idx == NW - 1) ? 1 : 0);
`ifdef CORR_SATURATE_EN
        check("beat_sat",   32'(out_sat),   e.sat);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    reset_n          = 1'b0;
    pulse_in         = '0;
    enable           = 1'b0;
    integration_time = '0;
    out_ready        = 1'b1;
    overrun_clear    = 1'b0;

    // Reset state
    cyc(3);
    check("rst_valid",   out_valid,   0);
    check("rst_index",   out_index,   0);
    check("rst_last",    out_last,    0);
    check("rst_tick",    window_tick, 0);
    check("rst_overrun", overrun,     0);
    reset_n = 1'b1;
    cyc(2);

    // enable with T=0: no ticks, no stream
    enable = 1'b1;
    seen   = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      seen = seen | int'(window_tick) | int'(out_valid);
    end
    check("t0_idle", seen, 0);
    enable = 1'b0;

    // Inputs 0 and 1 held high, T=100, with a 7-cycle stall at index 6
    pulse_in = 3'b011;
    cyc(10);
    build_const(3'b011, 100);
    push_stream(0);
    integration_time = 16'd100;
    enable = 1'b1;
    wait_tick(200);
    cyc(1);
    enable = 1'b0;
    wait_index(6, 50);
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      check("stall_valid", out_valid, 1);
      check("stall_index", out_index, 6);
      check("stall_data",  out_data,  exp_words[6]);
    end
    out_ready = 1'b1;
    wait_drain(100);

    // Input 0 pulses two cycles before input 1, ten times in the window
    pulse_in = '0;
    cyc(10);
    build_const(3'b000, 0);
    exp_words[0*LAGS + 3] = 10;
    exp_words[NP*LAGS + 0] = 10;
    exp_words[NP*LAGS + 1] = 10;
    push_stream(0);
    integration_time = 16'd100;
    enable = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      cyc(1);
      pulse_in[0] = ((c % 10) == 5);
      pulse_in[1] = ((c % 10) == 7);
      if (c == 99)  check("tick_early", window_tick, 0);
      if (c == 100) check("tick_end",   window_tick, 1);
    end
    cyc(1);
    enable   = 1'b0;
    pulse_in = '0;
    wait_drain(100);

    // Overrun: T=20, consumer stalled across two ticks
    pulse_in  = 3'b111;
    out_ready = 1'b0;
    cyc(10);
    build_const(3'b111, 20);
    push_stream(0);
    integration_time = 16'd20;
    enable = 1'b1;
    wait_tick(50);
    check("overrun_before", overrun, 0);
    wait_tick(50);
    cyc(1);
    enable = 1'b0;
    check("overrun_set",  overrun,   1);
    check("overrun_held", out_index, 0);
    out_ready = 1'b1;
    wait_drain(100);
    check("overrun_sticky", overrun, 1);
    overrun_clear = 1'b1;
    cyc(1);
    overrun_clear = 1'b0;
    check("overrun_clear", overrun, 0);

    // Counter limit: T=300 with 8-bit counters
    pulse_in = 3'b011;
    cyc(10);
`ifdef CORR_SATURATE_EN
    build_const(3'b011, 255);
    push_stream(1);
`else
    build_const(3'b011, 300 % 256);
    push_stream(0);
`endif
    integration_time = 16'd300;
    enable = 1'b1;
    wait_tick(400);
    cyc(1);
    enable = 1'b0;
    wait_drain(100);

    // Reset mid-stream at index 5
    pulse_in = 3'b100;
    cyc(10);
    build_const(3'b100, 30);
    push_stream(0);
    integration_time = 16'd30;
    enable = 1'b1;
    wait_tick(60);
    cyc(1);
    enable = 1'b0;
    wait_index(5, 50);
    out_ready = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_index", out_index, 0);
    check("abort_last",  out_last,  0);
    sb.delete();
    pulse_in = 3'b001;
    cyc(3);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    cyc(10);
    build_const(3'b001, 30);
    push_stream(0);
    enable = 1'b1;
    wait_tick(60);
    cyc(1);
    enable = 1'b0;
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
